// File: rtl/sonic_rx_sched_pkg.sv
// rtl/sonic_rx_sched_pkg.sv - state type and chunk sizing for the rx block scheduler
package sonic_rx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    MSI  = 2'd3
  } sched_state_t;

  // ring_end is 2^W - rptr and needs one bit more than a ring pointer, hence the wide operands
  function automatic logic [32:0] chunk_len(input logic [32:0] rem, input logic [32:0] ring_end);
    return (rem < ring_end) ? rem : ring_end;
  endfunction

endpackage

// File: rtl/sonic_constants.sv
// rtl/sonic_constants.sv - shared SoNIC build constants
`ifndef SONIC_CONSTANTS_SV
`define SONIC_CONSTANTS_SV

`define USED_QWORDS_WIDTH 8

`endif

// File: rtl/sonic_rx_block_scheduler.sv
// rtl/sonic_rx_block_scheduler.sv - issues per-block/per-chunk DMA reads from the rx ring and paces MSIs
`ifndef USED_QWORDS_WIDTH
`define USED_QWORDS_WIDTH 8
`endif

module sonic_rx_block_scheduler
  import sonic_rx_sched_pkg::*;
#(
  parameter int USED_QWORDS_WIDTH = `USED_QWORDS_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           rstn,
  input  logic                           enable_sfp,
  input  logic [USED_QWORDS_WIDTH-1:0]   rx_ring_wptr,
  input  logic [31:0]                    rx_block_size,
  input  logic                           irq_msi_enable,
  input  logic [7:0]                     blocks_per_irq,
  output logic                           dma_req,
  input  logic                           dma_ack,
  output logic [USED_QWORDS_WIDTH-2:0]   dma_addr_owords,
  output logic [USED_QWORDS_WIDTH-1:0]   dma_len_owords,
  input  logic                           dma_done,
  output logic                           app_msi_req,
  input  logic                           app_msi_ack,
  output logic [USED_QWORDS_WIDTH-1:0]   rx_ring_rptr,
  output logic [USED_QWORDS_WIDTH-1:0]   rx_avail_qwords,
  output logic [31:0]                    blocks_sent
);

  localparam int W = USED_QWORDS_WIDTH;

  sched_state_t state;
  logic [W-1:0] rptr, blk_rem, cur_chunk;
  logic [W-1:0] avail, blk, rem_eff, chunk, rem_after;
  logic [W:0]   ring_end;
  logic [32:0]  chunk_wide;
  logic [7:0]   irq_cnt, bpi;
  logic [8:0]   irq_next;
  logic         unused_bits;

  assign rx_ring_rptr = rptr;

  always_comb begin
    avail      = rx_ring_wptr - rptr;
    blk        = {rx_block_size[W-1:1], 1'b0};
    // an exhausted block picks up the current block size on its next issue
    rem_eff    = (blk_rem == '0) ? blk : blk_rem;
    ring_end   = {1'b1, {W{1'b0}}} - {1'b0, rptr};
    chunk_wide = chunk_len(33'(rem_eff), 33'(ring_end));
    chunk      = chunk_wide[W-1:0];
    rem_after  = blk_rem - cur_chunk;
    bpi        = (blocks_per_irq == 8'd0) ? 8'd1 : blocks_per_irq;
    irq_next   = {1'b0, irq_cnt} + 9'd1;
  end

  assign unused_bits = ^{rx_block_size[31:W], rx_block_size[0], chunk_wide[32:W]};

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      rptr            <= '0;
      blk_rem         <= '0;
      cur_chunk       <= '0;
      irq_cnt         <= '0;
      dma_req         <= 1'b0;
      dma_addr_owords <= '0;
      dma_len_owords  <= '0;
      app_msi_req     <= 1'b0;
      rx_avail_qwords <= '0;
      blocks_sent     <= '0;
    end else begin
      rx_avail_qwords <= avail;
      case (state)
        IDLE: begin
          if (!enable_sfp) begin
            rptr    <= '0;
            blk_rem <= '0;
            irq_cnt <= '0;
          end else if (blk != '0 && avail >= rem_eff) begin
            blk_rem         <= rem_eff;
            cur_chunk       <= chunk;
            dma_addr_owords <= rptr[W-1:1];
            dma_len_owords  <= chunk >> 1;
            dma_req         <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (!enable_sfp) begin
            dma_req <= 1'b0;
            rptr    <= '0;
            blk_rem <= '0;
            irq_cnt <= '0;
            state   <= IDLE;
          end else if (dma_ack) begin
            dma_req <= 1'b0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (dma_done) begin
            state <= IDLE;
            // a transfer finishing after the port was disabled is drained, never consumed
            if (!enable_sfp) begin
              rptr    <= '0;
              blk_rem <= '0;
              irq_cnt <= '0;
            end else begin
              rptr    <= rptr + cur_chunk;
              blk_rem <= rem_after;
              if (rem_after == '0) begin
                blocks_sent <= blocks_sent + 32'd1;
                if (irq_msi_enable && irq_next >= {1'b0, bpi}) begin
                  irq_cnt     <= '0;
                  app_msi_req <= 1'b1;
                  state       <= MSI;
                end else if (!irq_msi_enable && irq_next > {1'b0, bpi}) begin
                  irq_cnt <= bpi;
                end else begin
                  irq_cnt <= irq_next[7:0];
                end
              end
            end
          end
        end
        MSI: begin
          if (!enable_sfp) begin
            rptr    <= '0;
            blk_rem <= '0;
            irq_cnt <= '0;
          end
          if (app_msi_ack) begin
            app_msi_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_rx_block_scheduler.sv
// tb/tb_sonic_rx_block_scheduler.sv - self-checking bench for sonic_rx_block_scheduler (W=8)
`timescale 1ns/1ps
module tb_sonic_rx_block_scheduler;
  localparam int W = 8;

  logic clk_in = 1'b0;
  logic rstn, enable_sfp, irq_msi_enable, dma_ack, dma_done, app_msi_ack;
  logic [W-1:0] rx_ring_wptr;
  logic [31:0]  rx_block_size;
  logic [7:0]   blocks_per_irq;
  logic         dma_req, app_msi_req;
  logic [W-2:0] dma_addr_owords;
  logic [W-1:0] dma_len_owords, rx_ring_rptr, rx_avail_qwords;
  logic [31:0]  blocks_sent;

  int n_checks = 0;
  int n_fail = 0;
  int msi_pulses = 0;
  logic msi_prev = 1'b0;

  sonic_rx_block_scheduler #(.USED_QWORDS_WIDTH(W)) dut (
    .clk_in(clk_in), .rstn(rstn), .enable_sfp(enable_sfp),
    .rx_ring_wptr(rx_ring_wptr), .rx_block_size(rx_block_size),
    .irq_msi_enable(irq_msi_enable), .blocks_per_irq(blocks_per_irq),
    .dma_req(dma_req), .dma_ack(dma_ack), .dma_addr_owords(dma_addr_owords),
    .dma_len_owords(dma_len_owords), .dma_done(dma_done),
    .app_msi_req(app_msi_req), .app_msi_ack(app_msi_ack),
    .rx_ring_rptr(rx_ring_rptr), .rx_avail_qwords(rx_avail_qwords),
    .blocks_sent(blocks_sent)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    msi_prev <= app_msi_req;
    if (app_msi_req && !msi_prev) msi_pulses <= msi_pulses + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " dma_req"}, dma_req, 0);
    check({name, " addr"}, dma_addr_owords, 0);
    check({name, " len"}, dma_len_owords, 0);
    check({name, " msi_req"}, app_msi_req, 0);
    check({name, " rptr"}, rx_ring_rptr, 0);
    check({name, " avail"}, rx_avail_qwords, 0);
    check({name, " blocks_sent"}, blocks_sent, 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; enable_sfp = 1'b1; irq_msi_enable = 1'b0; dma_ack = 1'b0; dma_done = 1'b0;
    app_msi_ack = 1'b0; rx_ring_wptr = '0; rx_block_size = '0; blocks_per_irq = '0;
    tick(2);
    check_outputs_zero("reset");
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string name, output bit ok);
    int n = 0;
    while (!dma_req && n < 64) begin
      tick();
      n++;
    end
    ok = dma_req;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: dma_req got 0 expected 1 within 64 cycles", name);
    end
  endtask

  task automatic expect_no_req(input string name, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (dma_req) seen = 1'b1;
    end
    check(name, seen, 0);
  endtask

  task automatic do_chunk(input string name, input int exp_addr, input int exp_len,
                          input int ack_lat, input int done_lat);
    bit ok;
    wait_req(name, ok);
    if (!ok) return;
    check({name, " addr"}, dma_addr_owords, exp_addr);
    check({name, " len"}, dma_len_owords, exp_len);
    tick(ack_lat);
    check({name, " req held"}, dma_req, 1);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    check({name, " req drop"}, dma_req, 0);
    tick(done_lat);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
  endtask

  typedef struct {
    logic [31:0] blk;
    logic [7:0]  wptr;
    bit          req;
    int          addr;
    int          len;
    int          rptr_after;
    int          bs_after;
  } vec_t;

  vec_t tbl[8];
  int mr, bs, ic, b, first, blk, partial, bpi_eff;
  bit en, exp_msi;

  initial begin
    tbl[0] = '{32'd64, 8'd63,  1'b0, 0,   0,  0,   0};
    tbl[1] = '{32'd64, 8'd64,  1'b1, 0,   32, 64,  1};
    tbl[2] = '{32'd65, 8'd128, 1'b1, 32,  32, 128, 2};
    tbl[3] = '{32'd64, 8'd192, 1'b1, 64,  32, 192, 3};
    tbl[4] = '{32'd32, 8'd223, 1'b0, 0,   0,  192, 3};
    tbl[5] = '{32'd32, 8'd224, 1'b1, 96,  16, 224, 4};
    tbl[6] = '{32'd64, 8'd32,  1'b1, 112, 16, 0,   4};
    tbl[7] = '{32'd64, 8'd32,  1'b1, 0,   16, 32,  5};

    do_reset();
    mr = 0;
    for (int i = 0; i < 8; i++) begin
      rx_block_size = tbl[i].blk;
      rx_ring_wptr = tbl[i].wptr;
      tick(3);
      check($sformatf("vec%0d avail", i), rx_avail_qwords, (int'(tbl[i].wptr) - mr) & 255);
      check($sformatf("vec%0d req", i), dma_req, tbl[i].req);
      if (tbl[i].req) do_chunk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].len, i % 3, 1 + i % 2);
      check($sformatf("vec%0d rptr", i), rx_ring_rptr, tbl[i].rptr_after);
      check($sformatf("vec%0d blocks", i), blocks_sent, tbl[i].bs_after);
      mr = tbl[i].rptr_after;
    end

    // MSI cadence: every third block, none while disabled, immediate on re-enable
    do_reset();
    blocks_per_irq = 8'd3; irq_msi_enable = 1'b1; rx_block_size = 32'd16;
    mr = 0; b = msi_pulses;
    for (int k = 1; k <= 10; k++) begin
      if (k == 7) irq_msi_enable = 1'b0;
      if (k == 10) irq_msi_enable = 1'b1;
      rx_ring_wptr = 8'(mr + 16);
      do_chunk($sformatf("msi blk%0d", k), (mr % 256) / 2, 8, 0, 0);
      mr += 16;
      exp_msi = (k == 3 || k == 6 || k == 10);
      check($sformatf("msi blk%0d msi_req", k), app_msi_req, exp_msi);
      if (exp_msi) begin
        tick(2);
        check($sformatf("msi blk%0d hold", k), app_msi_req, 1);
        app_msi_ack = 1'b1;
        tick();
        app_msi_ack = 1'b0;
        check($sformatf("msi blk%0d release", k), app_msi_req, 0);
      end
      if (k == 9) check("msi pulses", msi_pulses - b, 2);
    end

    // disable while requesting, then stray ack/done while idle
    do_reset();
    rx_block_size = 32'd16; rx_ring_wptr = 8'd16;
    wait_req("dis_req", en);
    enable_sfp = 1'b0; rx_ring_wptr = 8'd0;
    tick();
    check("dis_req dma_req", dma_req, 0);
    check("dis_req rptr", rx_ring_rptr, 0);
    enable_sfp = 1'b1;
    expect_no_req("dis_req idle", 5);
    dma_ack = 1'b1; dma_done = 1'b1;
    tick();
    dma_ack = 1'b0; dma_done = 1'b0;
    tick(2);
    check("stray rptr", rx_ring_rptr, 0);
    check("stray blocks", blocks_sent, 0);
    check("stray req", dma_req, 0);

    // disable during transfer
    do_reset();
    rx_block_size = 32'd16; rx_ring_wptr = 8'd16;
    wait_req("dis_xfer", en);
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0; enable_sfp = 1'b0; rx_ring_wptr = 8'd0;
    tick(3);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("dis_xfer rptr", rx_ring_rptr, 0);
    check("dis_xfer blocks", blocks_sent, 0);
    tick(2);
    enable_sfp = 1'b1; rx_ring_wptr = 8'd16;
    do_chunk("dis_xfer reissue", 0, 8, 1, 1);
    check("dis_xfer reissue rptr", rx_ring_rptr, 16);
    check("dis_xfer reissue blocks", blocks_sent, 1);

    // asynchronous reset while an MSI is pending
    do_reset();
    blocks_per_irq = 8'd0; irq_msi_enable = 1'b1; rx_block_size = 32'd16; rx_ring_wptr = 8'd16;
    do_chunk("rst_msi", 0, 8, 0, 1);
    check("rst_msi msi_req", app_msi_req, 1);
    #2 rstn = 1'b0;
    #1;
    check_outputs_zero("async reset");
    rx_ring_wptr = 8'd8;
    tick();
    rstn = 1'b1;
    expect_no_req("rst_msi no spurious", 6);

    // randomized blocks against the ring/block reference model
    do_reset();
    mr = 0; bs = 0; ic = 0;
    for (int k = 0; k < 30; k++) begin
      blk = 2 * $urandom_range(1, 80);
      rx_block_size = ($urandom & 32'hFFFF_FF00) | 32'(blk) | 32'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      irq_msi_enable = en;
      blocks_per_irq = 8'($urandom_range(0, 4));
      partial = $urandom_range(0, blk - 1);
      rx_ring_wptr = 8'(mr + partial);
      expect_no_req($sformatf("rnd%0d partial", k), 3);
      check($sformatf("rnd%0d avail", k), rx_avail_qwords, partial);
      rx_ring_wptr = 8'(mr + blk);
      first = (blk < 256 - (mr % 256)) ? blk : 256 - (mr % 256);
      do_chunk($sformatf("rnd%0d c0", k), (mr % 256) / 2, first / 2,
               $urandom_range(0, 3), $urandom_range(0, 4));
      if (first < blk)
        do_chunk($sformatf("rnd%0d c1", k), 0, (blk - first) / 2,
                 $urandom_range(0, 3), $urandom_range(0, 4));
      mr += blk; bs++;
      bpi_eff = (blocks_per_irq == 0) ? 1 : int'(blocks_per_irq);
      ic++;
      exp_msi = 1'b0;
      if (en && ic >= bpi_eff) begin
        ic = 0;
        exp_msi = 1'b1;
      end else if (!en && ic > bpi_eff) begin
        ic = bpi_eff;
      end
      check($sformatf("rnd%0d rptr", k), rx_ring_rptr, mr % 256);
      check($sformatf("rnd%0d blocks", k), blocks_sent, bs);
      check($sformatf("rnd%0d msi", k), app_msi_req, exp_msi);
      if (app_msi_req) begin
        tick($urandom_range(0, 3));
        app_msi_ack = 1'b1;
        tick();
        app_msi_ack = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
